irq_gate: RTL and testbench
===========================

IRQ_GATE -- requirements
Module: irq_gate

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: src  in  7  raw peripheral interrupt levels, src[n-1] for line n.
REQ-004 SHALL have ports: cfg_we  in  1  config write strobe, one write per cycle.
REQ-005 SHALL have ports: cfg_sel  in  2  register select: 0 mask, 1 mode, 2 holdoff, 3 pending W1C.
REQ-006 SHALL have ports: cfg_data  in  16  write data.
REQ-007 SHALL have ports: status  out  16  {1'b0, pending[6:0], 1'b0, mask[6:0]}, combinational from registers.
REQ-008 SHALL have ports: irq1..irq7  out  1 each  registered single-cycle request pulses to irqcollector.
REQ-009 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-010 SHALL hold per-line state: mask (1 = enabled), mode (0 = rising edge, 1 = level), pending, prev sample, and an 8-bit holdoff counter; shared holdoff reload value is 8 bits.
REQ-011 SHALL detect an event on line n when mask[n]=1 and either edge mode with sample=1, prev=0, or level mode with sample=1.
REQ-012 SHALL update prev every cycle regardless of mask; enabling a mask while src is already high in edge mode SHALL NOT produce an event.
REQ-013 SHALL compute pending_next = (pending & ~emit & ~w1c & mask_next) | event; the event term SHALL take priority over emit and W1C.
REQ-014 SHALL emit on line n when pending[n]=1 and cnt[n]=0; on that edge irqN <= 1 for one cycle, pending[n] clears (unless REQ-013 event), and cnt[n] <= holdoff.
REQ-015 SHALL decrement cnt[n] each cycle while nonzero, saturating at 0; holdoff=0 SHALL permit a pulse every cycle on a held level line.
REQ-016 SHALL drive irqN low in every cycle without an emit; multiple lines MAY pulse in the same cycle.
REQ-017 SHALL apply cfg writes on the edge they are presented: sel0 mask <= data[6:0], sel1 mode <= data[6:0], sel2 holdoff <= data[7:0], sel3 pending &= ~data[6:0]; upper data bits ignored.
REQ-018 SHALL clear pending[n] on the same edge that a mask write clears mask[n].
REQ-019 SHALL produce the first irqN pulse at edge k+3 with IRQ_SYNC_EN and at edge k+2 without it, where k is the first edge that samples src high (counter idle).
REQ-020 SHALL let a holdoff reload written mid-count affect only subsequent reloads, not running counters.

Reset
REQ-021 SHALL on rst clear mask, mode, pending, prev, synchronizer flops, cnt, and all irqN; holdoff SHALL reset to 8 (one irqcollector scan period).
REQ-022 SHALL abort any pending or counting activity when rst asserts mid-operation; irqN SHALL be 0 on the edge after rst is sampled and no event SHALL be generated from pre-reset levels until a fresh edge.

Configuration
REQ-023 SHALL, with IRQ_SYNC_EN defined, pass each src bit through a 2-flop synchronizer before the sample/prev stage (latency per REQ-019).
REQ-024 SHALL, without IRQ_SYNC_EN, register src once directly into the sample stage; all other behaviour SHALL be identical.

Verification
REQ-025 SHALL cover: mask=0x7F, mode=0, src[0] 0->1 held 20 cycles -> exactly one irq1 pulse at k+3 (sync) / k+2 (no sync).
REQ-026 SHALL cover: mode=0x04, holdoff=3, mask=0x04, src[2] held high -> irq3 pulses every 4 cycles; holdoff=0 -> every cycle.
REQ-027 SHALL cover: holdoff=10, src[4] two edges 3 cycles apart -> first irq5 at latency, second exactly 11 cycles later, pending visible in status[12] between them.
REQ-028 SHALL cover: pending[1] set during holdoff, write sel3 data=0x0002 -> status[9]=0 next cycle, no irq2; same-cycle new edge with W1C -> pending stays 1.
REQ-029 SHALL cover: rst asserted while pending=0x7F and counters nonzero -> next cycle status=0x0000, all irqN=0, holdoff reads back as default 8 via a level-mode pulse spacing of 9.

Source files
------------

// File: rtl/irq_gate.sv
// irq_gate: per-line interrupt capture with edge/level detection, masking and holdoff throttling.
// Define IRQ_SYNC_EN to add a two-flop input synchronizer (one extra cycle of latency).
module irq_gate (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  src,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_sel,
    input  logic [15:0] cfg_data,
    output logic [15:0] status,
    output logic        irq1,
    output logic        irq2,
    output logic        irq3,
    output logic        irq4,
    output logic        irq5,
    output logic        irq6,
    output logic        irq7
);

    localparam logic [7:0] HoldoffRst = 8'd8;
    localparam logic [1:0] SelMask    = 2'd0;
    localparam logic [1:0] SelMode    = 2'd1;
    localparam logic [1:0] SelHold    = 2'd2;
    localparam logic [1:0] SelW1c     = 2'd3;

    logic [6:0]      r_sample;
    logic [6:0]      r_prev;
    logic [6:0]      r_mask;
    logic [6:0]      r_mode;
    logic [6:0]      r_pend;
    logic [6:0]      r_irq;
    logic [7:0]      r_hold;
    logic [6:0][7:0] r_cnt;

    logic [6:0] w_event;
    logic [6:0] w_emit;
    logic [6:0] w_w1c;
    logic [6:0] w_mask_next;
    logic [6:0] w_pend_next;
    logic       w_unused;

    assign w_unused = ^cfg_data[15:8];

`ifdef IRQ_SYNC_EN
    logic [6:0] r_meta;

    // r_sample doubles as the second synchronizer flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= '0;
            r_sample <= '0;
        end else begin
            r_meta   <= src;
            r_sample <= r_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
        end else begin
            r_sample <= src;
        end
    end
`endif

    always_comb begin
        w_event     = r_mask & r_sample & (r_mode | ~r_prev);
        w_emit      = '0;
        for (int n = 0; n < 7; n++) begin
            w_emit[n] = r_pend[n] && (r_cnt[n] == 8'd0);
        end
        w_mask_next = (cfg_we && (cfg_sel == SelMask)) ? cfg_data[6:0] : r_mask;
        w_w1c       = (cfg_we && (cfg_sel == SelW1c)) ? cfg_data[6:0] : 7'd0;
        // A fresh event wins over both the emit clear and a W1C on the same edge.
        w_pend_next = (r_pend & ~w_emit & ~w_w1c & w_mask_next) | w_event;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
            r_mask <= '0;
            r_mode <= '0;
            r_pend <= '0;
            r_irq  <= '0;
            r_hold <= HoldoffRst;
            r_cnt  <= '0;
        end else begin
            r_prev <= r_sample;
            r_mask <= w_mask_next;
            r_pend <= w_pend_next;
            r_irq  <= w_emit;
            if (cfg_we && (cfg_sel == SelMode)) begin
                r_mode <= cfg_data[6:0];
            end
            if (cfg_we && (cfg_sel == SelHold)) begin
                r_hold <= cfg_data[7:0];
            end
            for (int n = 0; n < 7; n++) begin
                if (w_emit[n]) begin
                    r_cnt[n] <= r_hold;
                end else if (r_cnt[n] != 8'd0) begin
                    r_cnt[n] <= r_cnt[n] - 8'd1;
                end
            end
        end
    end

    assign status = {1'b0, r_pend, 1'b0, r_mask};

    assign irq1 = r_irq[0];
    assign irq2 = r_irq[1];
    assign irq3 = r_irq[2];
    assign irq4 = r_irq[3];
    assign irq5 = r_irq[4];
    assign irq6 = r_irq[5];
    assign irq7 = r_irq[6];

endmodule

// File: tb/tb_irq_gate.sv
// tb_irq_gate: directed scenarios plus randomized traffic, checked every cycle against a
// timestamp-based reference model of irq_gate.
module tb_irq_gate;

`ifdef IRQ_SYNC_EN
    localparam int D   = 1;
    localparam int LAT = 3;
`else
    localparam int D   = 0;
    localparam int LAT = 2;
`endif
    localparam int NH = 8192;

    logic        clk;
    logic        rst;
    logic [6:0]  src;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic [15:0] status;
    logic        irq1, irq2, irq3, irq4, irq5, irq6, irq7;

    irq_gate u_dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .status   (status),
        .irq1     (irq1),
        .irq2     (irq2),
        .irq3     (irq3),
        .irq4     (irq4),
        .irq5     (irq5),
        .irq6     (irq6),
        .irq7     (irq7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the input history is recorded per edge; holdoff is tracked as the
    // earliest edge number at which each line may fire again.
    logic [6:0] h_src [NH];
    logic       h_rst [NH];
    int         n_edge = 0;
    logic [6:0] m_mask, m_mode, m_pend, m_irq;
    int         m_hold;
    int         next_ok [7];
    logic [6:0] cur_src;
    logic [6:0] obs_irq;

    function automatic logic [6:0] smp(input int e);
        if (e - D < 0) return 7'd0;
        for (int j = 0; j <= D; j++) begin
            if (h_rst[e-j]) return 7'd0;
        end
        return h_src[e-D];
    endfunction

    task automatic model_edge();
        logic [6:0] s_now, p_now, w1c, mnext;
        logic       ev, em;
        int         e;
        e = n_edge;
        h_src[e] = src;
        h_rst[e] = rst;
        if (rst) begin
            m_mask = '0; m_mode = '0; m_pend = '0; m_irq = '0; m_hold = 8;
            for (int n = 0; n < 7; n++) next_ok[n] = 0;
        end else begin
            s_now = smp(e - 1);
            p_now = smp(e - 2);
            mnext = (cfg_we && cfg_sel == 2'd0) ? cfg_data[6:0] : m_mask;
            w1c   = (cfg_we && cfg_sel == 2'd3) ? cfg_data[6:0] : 7'd0;
            for (int n = 0; n < 7; n++) begin
                ev = m_mask[n] && s_now[n] && (m_mode[n] || !p_now[n]);
                em = m_pend[n] && (e >= next_ok[n]);
                if (em) next_ok[n] = e + m_hold + 1;
                m_irq[n]  = em;
                m_pend[n] = ev || (m_pend[n] && !em && !w1c[n] && mnext[n]);
            end
            if (cfg_we && cfg_sel == 2'd1) m_mode = cfg_data[6:0];
            if (cfg_we && cfg_sel == 2'd2) m_hold = int'(cfg_data[7:0]);
            m_mask = mnext;
        end
        n_edge++;
    endtask

    task automatic step(input logic r, input logic [6:0] s, input logic we,
                        input logic [1:0] sel, input logic [15:0] d);
        rst = r; src = s; cfg_we = we; cfg_sel = sel; cfg_data = d;
        cur_src = s;
        @(posedge clk);
        model_edge();
        #1;
        obs_irq = {irq7, irq6, irq5, irq4, irq3, irq2, irq1};
        check("status", 32'(status), 32'({1'b0, m_pend, 1'b0, m_mask}));
        check("irq", 32'(obs_irq), 32'(m_irq));
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] d);
        step(1'b0, cur_src, 1'b1, sel, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, cur_src, 1'b0, 2'd0, 16'd0);
    endtask

    // Holds inputs and returns the index of the first pulse on a line and the gap to the next.
    task automatic measure(input int line, input int budget, output int first, output int gap);
        int seen;
        seen = 0; first = -1; gap = -1;
        for (int j = 0; j < budget && seen < 2; j++) begin
            step(1'b0, cur_src, 1'b0, 2'd0, 16'd0);
            if (obs_irq[line]) begin
                if (seen == 0) first = j;
                else gap = j - first;
                seen++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first, gap, cnt;
        logic [6:0]  s;
        logic [15:0] d;
        logic [1:0]  sel;
        cur_src = '0;
        rst = 1'b1; src = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
        #2;
        step(1'b1, 7'h00, 1'b0, 2'd0, 16'd0);
        step(1'b1, 7'h00, 1'b0, 2'd0, 16'd0);
        check("reset_status", 32'(status), 32'h0);
        check("reset_irq", 32'(obs_irq), 32'h0);

        // Single rising edge on line 1, held high.
        wr(2'd0, 16'h007F);
        wr(2'd1, 16'h0000);
        idle(3);
        first = -1; cnt = 0;
        for (int j = 0; j < 20; j++) begin
            step(1'b0, 7'h01, 1'b0, 2'd0, 16'd0);
            if (obs_irq[0]) begin
                if (first < 0) first = j;
                cnt++;
            end
        end
        check("edge_latency", 32'(first), 32'(LAT));
        check("edge_count", 32'(cnt), 32'd1);
        step(1'b0, 7'h00, 1'b1, 2'd0, 16'h0000);
        idle(3);

        // Level line 3 throttled by holdoff 3, then by holdoff 0.
        wr(2'd1, 16'h0004);
        wr(2'd2, 16'h0003);
        wr(2'd0, 16'h0004);
        step(1'b0, 7'h04, 1'b0, 2'd0, 16'd0);
        measure(2, 40, first, gap);
        check("level_gap_h3", 32'(gap), 32'd4);
        wr(2'd2, 16'h0000);
        idle(6);
        measure(2, 40, first, gap);
        check("level_gap_h0", 32'(gap), 32'd1);
        step(1'b0, 7'h00, 1'b1, 2'd0, 16'h0000);
        wr(2'd1, 16'h0000);
        idle(4);

        // Two edges on line 5 three cycles apart under holdoff 10.
        wr(2'd2, 16'h000A);
        wr(2'd0, 16'h0010);
        idle(3);
        first = -1; gap = -1; cnt = 0;
        for (int j = 0; j < 30; j++) begin
            step(1'b0, (j == 0 || j == 3) ? 7'h10 : 7'h00, 1'b0, 2'd0, 16'd0);
            if (j == LAT + 3) check("pend_visible", 32'(status[12]), 32'd1);
            if (obs_irq[4]) begin
                if (cnt == 0) first = j;
                else if (cnt == 1) gap = j - first;
                cnt++;
            end
        end
        check("holdoff_first", 32'(first), 32'(LAT));
        check("holdoff_gap", 32'(gap), 32'd11);
        step(1'b0, 7'h00, 1'b1, 2'd0, 16'h0000);
        idle(12);

        // W1C on line 2 during holdoff, and W1C colliding with a fresh edge.
        wr(2'd2, 16'd20);
        wr(2'd0, 16'h0002);
        idle(2);
        step(1'b0, 7'h02, 1'b0, 2'd0, 16'd0);
        idle(0);
        step(1'b0, 7'h00, 1'b0, 2'd0, 16'd0);
        step(1'b0, 7'h00, 1'b0, 2'd0, 16'd0);
        step(1'b0, 7'h00, 1'b0, 2'd0, 16'd0);
        step(1'b0, 7'h02, 1'b0, 2'd0, 16'd0);
        step(1'b0, 7'h00, 1'b0, 2'd0, 16'd0);
        step(1'b0, 7'h00, 1'b0, 2'd0, 16'd0);
        check("pend_before_w1c", 32'(status[9]), 32'd1);
        step(1'b0, 7'h00, 1'b1, 2'd3, 16'h0002);
        check("w1c_clears", 32'(status[9]), 32'd0);
        cnt = 0;
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 7'h00, 1'b0, 2'd0, 16'd0);
            cnt += int'(obs_irq[1]);
        end
        for (int j = 0; j < LAT - 1; j++) begin
            step(1'b0, 7'h02, 1'b0, 2'd0, 16'd0);
            cnt += int'(obs_irq[1]);
        end
        step(1'b0, 7'h02, 1'b1, 2'd3, 16'h0002);
        cnt += int'(obs_irq[1]);
        check("w1c_no_irq", 32'(cnt), 32'd0);
        check("event_beats_w1c", 32'(status[9]), 32'd1);
        step(1'b0, 7'h00, 1'b1, 2'd0, 16'h0000);
        idle(3);

        // Reset mid-activity, then default holdoff seen as a level pulse spacing of 9.
        step(1'b0, 7'h7F, 1'b0, 2'd0, 16'd0);
        wr(2'd2, 16'd50);
        wr(2'd1, 16'h007F);
        wr(2'd0, 16'h007F);
        idle(6);
        check("pend_all", 32'(status[14:8]), 32'h7F);
        step(1'b1, 7'h7F, 1'b0, 2'd0, 16'd0);
        check("rst_mid_status", 32'(status), 32'h0);
        check("rst_mid_irq", 32'(obs_irq), 32'h0);
        wr(2'd1, 16'h0001);
        wr(2'd0, 16'h0001);
        measure(0, 40, first, gap);
        check("default_holdoff_gap", 32'(gap), 32'd9);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            s   = cur_src ^ (7'($urandom) & 7'($urandom));
            sel = 2'($urandom);
            d   = 16'($urandom);
            if (sel == 2'd2) d[7:0] = 8'($urandom_range(0, 6));
            step(($urandom_range(0, 99) == 0), s, ($urandom_range(0, 2) == 0), sel, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
